wordle_letter_tx: RTL and testbench
===================================

Name: wordle_letter_tx

Overview:
- Transmit end of the keyboard-letter interface that feeds the Wordle guess state machine.
- Converts debounced Nexys4 button pulses into ASCII capital letters: Up/Down scroll A..Z, Center commits.
- Sends each committed letter over a valid/ready handshake and tracks position within the current guess.
- Pulses word_sent after WORD_LEN letters have been accepted, so the display and game logic can advance rows.

Parameters:
- WORD_LEN, 5, letters per guess; pos counter wraps to 0 after WORD_LEN transfers.
- KEEP_LETTER, 0, 1 = sel_letter keeps its value after a transfer; 0 = sel_letter returns to "A".

Ports:
- Clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  high while the game is in any guess state.
- BtnU_pulse  input  1  one-cycle debounced pulse: next letter.
- BtnD_pulse  input  1  one-cycle debounced pulse: previous letter.
- BtnC_pulse  input  1  one-cycle debounced pulse: commit the selected letter.
- letter_ready  input  1  receiver accepts letter_out this cycle.
- letter_out  output  8  ASCII letter being transmitted.
- letter_valid  output  1  letter_out is valid; held high until accepted.
- sel_letter  output  8  currently highlighted ASCII letter, for the SSD/VGA display.
- pos  output  3  index of the next letter in the guess, 0..WORD_LEN-1.
- word_sent  output  1  one-cycle pulse when the last letter of a guess is accepted.
- q_Dis, q_Sel, q_Send, q_End  output  1 each  one-hot state flags.

Behaviour:
- Reset (reset=0, asynchronous): state=DIS, sel_letter=8'h41 ("A"), letter_out=8'h00, letter_valid=0, pos=0, word_sent=0.
- States, one-hot: DIS, SEL, SEND, END. Exactly one state flag is high at all times.
- enable=0 in any state: next state is DIS. letter_valid drops the next cycle, even mid-SEND (abort is allowed; the receiver has already left the guess states). pos is cleared to 0 and sel_letter is set to "A". This rule overrides every other transition.
- DIS: all buttons are ignored. When enable=1, next state is SEL.
- SEL, BtnC_pulse: register letter_out=sel_letter, set letter_valid=1, go to SEND. Latency from the BtnC cycle n to letter_valid high is exactly 1 cycle (cycle n+1).
- SEL, BtnC with BtnU or BtnD in the same cycle: BtnC wins. The pre-scroll letter is committed and sel_letter is unchanged.
- SEL, BtnU alone: sel_letter+1, wrapping 8'h5A -> 8'h41.
- SEL, BtnD alone: sel_letter-1, wrapping 8'h41 -> 8'h5A.
- SEL, BtnU and BtnD together (no BtnC): sel_letter is unchanged.
- SEND: letter_out and letter_valid stay stable until a cycle with letter_ready=1 (the transfer). All buttons are ignored.
- On transfer with pos<WORD_LEN-1: the next cycle has letter_valid=0 and state SEL. pos increments by 1. sel_letter is kept if KEEP_LETTER=1, otherwise set to "A".
- On transfer with pos==WORD_LEN-1: next state is END, letter_valid=0.
- letter_ready=1 while letter_valid=0 is ignored.
- END: word_sent=1 for exactly this one cycle. pos=0 and the sel_letter rule above applies. Next state is SEL if enable=1, otherwise DIS.
- Throughput: at most one letter per 2 cycles (SEL -> SEND with ready already high -> SEL).
- pos never exceeds WORD_LEN-1. Its width is fixed at 3 bits, so WORD_LEN must be <= 8.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package holds:
  - ASCII_A=8'h41 and ASCII_Z=8'h5A.
  - Tx state one-hot encodings QDIS=4'b1000, QSEL=4'b0100, QSEND=4'b0010, QEND=4'b0001.
  - WORD_LEN default, shared with the guess state machine.
- One sub-module is natural: letter_cycler, which is combinational. Inputs are cur[7:0], up and down; output is nxt[7:0]. It implements the A..Z wrap arithmetic and the up&down no-op. It is reusable by the display highlight logic.

Test Plan:
- Reset then enable=1, BtnC at cycle n with letter_ready=1 at n+1 -> letter_valid=1 with letter_out=8'h41 at n+1; letter_valid=0, pos=1 at n+2.
- From "A", one BtnD -> sel_letter=8'h5A. From "Z", one BtnU -> 8'h41. BtnU and BtnD in the same cycle -> unchanged.
- Commit "R","E","N","E","W" with letter_ready tied high -> exactly five valid transfers in that order, then word_sent high for 1 cycle, then pos=0 and state SEL.
- Hold letter_ready=0 for 10 cycles after a commit, pulsing BtnU -> letter_valid stays 1, letter_out is unchanged, sel_letter is unchanged. Raise ready -> one transfer only.
- In SEND, drop enable -> next cycle letter_valid=0, state DIS, pos=0, sel_letter=8'h41. Buttons have no effect until enable returns.
- Assert reset=0 asynchronously mid-SEND at pos=3 -> all outputs take their reset values immediately, without waiting for a Clk edge.

Source files
------------

// File: rtl/wordle_letter_tx_pkg.sv
// wordle_letter_tx_pkg: shared letter constants and tx state encodings
package wordle_letter_tx_pkg;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_Z = 8'h5A;
    localparam int WORD_LEN_DEF = 5;
    typedef enum logic [3:0] {
        QDIS  = 4'b1000,
        QSEL  = 4'b0100,
        QSEND = 4'b0010,
        QEND  = 4'b0001
    } tx_state_t;
endpackage

// File: rtl/wordle_letter_tx_letter_cycler.sv
// letter_cycler: steps an ASCII capital up or down with A..Z wraparound
module letter_cycler
    import wordle_letter_tx_pkg::*;
(
    input  logic [7:0] cur,
    input  logic       up,
    input  logic       down,
    output logic [7:0] nxt
);
    // pressing both directions at once cancels out
    always_comb begin
        nxt = (up && !down) ? ((cur == ASCII_Z) ? ASCII_A : cur + 8'd1) :
              (down && !up) ? ((cur == ASCII_A) ? ASCII_Z : cur - 8'd1) : cur;
    end
endmodule

// File: rtl/wordle_letter_tx.sv
// wordle_letter_tx: button-driven letter picker that hands committed letters to the guess FSM
module wordle_letter_tx
    import wordle_letter_tx_pkg::*;
#(
    parameter int WORD_LEN    = WORD_LEN_DEF,
    parameter bit KEEP_LETTER = 1'b0
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       BtnU_pulse,
    input  logic       BtnD_pulse,
    input  logic       BtnC_pulse,
    input  logic       letter_ready,
    output logic [7:0] letter_out,
    output logic       letter_valid,
    output logic [7:0] sel_letter,
    output logic [2:0] pos,
    output logic       word_sent,
    output logic       q_Dis,
    output logic       q_Sel,
    output logic       q_Send,
    output logic       q_End
);
    tx_state_t  r_state, w_next;
    logic [7:0] r_sel, r_out, w_sel, w_out, w_cyc;
    logic [2:0] r_pos, w_pos;
    logic       r_valid, r_ws, w_valid, w_ws;
    logic [7:0] w_after;

    letter_cycler u_cycler (
        .cur  (r_sel),
        .up   (BtnU_pulse),
        .down (BtnD_pulse),
        .nxt  (w_cyc)
    );

    assign w_after = KEEP_LETTER ? r_sel : ASCII_A;

    // next state and next register values; dropping enable overrides everything
    always_comb begin
        w_next  = r_state;
        w_sel   = r_sel;
        w_out   = r_out;
        w_valid = r_valid;
        w_pos   = r_pos;
        w_ws    = 1'b0;
        if (!enable) begin
            w_next  = QDIS;
            w_sel   = ASCII_A;
            w_valid = 1'b0;
            w_pos   = 3'd0;
        end else begin
            case (r_state)
                QDIS: w_next = QSEL;
                QSEL: begin
                    if (BtnC_pulse) begin
                        w_next  = QSEND;
                        w_out   = r_sel;
                        w_valid = 1'b1;
                    end else begin
                        w_sel = w_cyc;
                    end
                end
                QSEND: begin
                    if (letter_ready) begin
                        w_valid = 1'b0;
                        w_sel   = w_after;
                        w_next  = (r_pos == 3'(WORD_LEN - 1)) ? QEND : QSEL;
                        w_pos   = (r_pos == 3'(WORD_LEN - 1)) ? 3'd0 : r_pos + 3'd1;
                        w_ws    = (r_pos == 3'(WORD_LEN - 1));
                    end
                end
                QEND:    w_next = QSEL;
                default: w_next = QDIS;
            endcase
        end
    end

    // every output comes straight from a register
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= QDIS;
            r_sel   <= ASCII_A;
            r_out   <= 8'h00;
            r_valid <= 1'b0;
            r_pos   <= 3'd0;
            r_ws    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sel   <= w_sel;
            r_out   <= w_out;
            r_valid <= w_valid;
            r_pos   <= w_pos;
            r_ws    <= w_ws;
        end
    end

    assign letter_out   = r_out;
    assign letter_valid = r_valid;
    assign sel_letter   = r_sel;
    assign pos          = r_pos;
    assign word_sent    = r_ws;
    assign q_Dis        = r_state[3];
    assign q_Sel        = r_state[2];
    assign q_Send       = r_state[1];
    assign q_End        = r_state[0];
endmodule

// File: tb/tb_wordle_letter_tx.sv
// tb_wordle_letter_tx: directed stimulus with a transfer scoreboard checked by a monitor
module tb_wordle_letter_tx;
    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       BtnU_pulse = 1'b0;
    logic       BtnD_pulse = 1'b0;
    logic       BtnC_pulse = 1'b0;
    logic       letter_ready = 1'b0;
    logic [7:0] letter_out, sel_letter;
    logic       letter_valid, word_sent, q_Dis, q_Sel, q_Send, q_End;
    logic [2:0] pos;
    int         errors = 0;
    int         checks = 0;
    int         n_xfer = 0;
    logic [7:0] exp_q[$];

    always #5 Clk = ~Clk;

    wordle_letter_tx dut (
        .Clk          (Clk),
        .reset        (reset),
        .enable       (enable),
        .BtnU_pulse   (BtnU_pulse),
        .BtnD_pulse   (BtnD_pulse),
        .BtnC_pulse   (BtnC_pulse),
        .letter_ready (letter_ready),
        .letter_out   (letter_out),
        .letter_valid (letter_valid),
        .sel_letter   (sel_letter),
        .pos          (pos),
        .word_sent    (word_sent),
        .q_Dis        (q_Dis),
        .q_Sel        (q_Sel),
        .q_Send       (q_Send),
        .q_End        (q_End)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic press(input bit up, input int n);
        repeat (n) begin
            if (up) BtnU_pulse = 1'b1;
            else BtnD_pulse = 1'b1;
            tick();
            BtnU_pulse = 1'b0;
            BtnD_pulse = 1'b0;
        end
    endtask

    task automatic send_letter(input logic [7:0] l, input bit up, input int n, input logic [2:0] exp_pos);
        press(up, n);
        chk("scroll_sel", sel_letter, l);
        exp_q.push_back(l);
        BtnC_pulse = 1'b1;
        tick();
        BtnC_pulse = 1'b0;
        chk("commit_valid", letter_valid, 1'b1);
        chk("commit_out", letter_out, l);
        tick();
        chk("after_xfer_valid", letter_valid, 1'b0);
        chk("after_xfer_pos", pos, exp_pos);
    endtask

    // scoreboard monitor: each accepted letter must match the oldest committed one
    always @(negedge Clk) begin
        if (reset) chk("onehot", $onehot({q_Dis, q_Sel, q_Send, q_End}), 1'b1);
        if (reset && letter_valid && letter_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer: unexpected letter %0h, none expected", letter_out);
            end else begin
                chk("xfer_letter", letter_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #12;
        chk("rst_sel", sel_letter, 8'h41);
        chk("rst_out", letter_out, 8'h00);
        chk("rst_valid", letter_valid, 1'b0);
        chk("rst_pos", pos, 3'd0);
        chk("rst_ws", word_sent, 1'b0);
        chk("rst_dis", q_Dis, 1'b1);
        reset = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        chk("enter_sel", q_Sel, 1'b1);
        exp_q.push_back(8'h41);
        BtnC_pulse = 1'b1;
        tick();
        BtnC_pulse = 1'b0;
        letter_ready = 1'b1;
        chk("lat_valid", letter_valid, 1'b1);
        chk("lat_out", letter_out, 8'h41);
        tick();
        chk("lat_done_valid", letter_valid, 1'b0);
        chk("lat_pos", pos, 3'd1);
        letter_ready = 1'b0;
        press(1'b0, 1);
        chk("wrap_down", sel_letter, 8'h5A);
        press(1'b1, 1);
        chk("wrap_up", sel_letter, 8'h41);
        BtnU_pulse = 1'b1;
        BtnD_pulse = 1'b1;
        tick();
        BtnU_pulse = 1'b0;
        BtnD_pulse = 1'b0;
        chk("ud_noop", sel_letter, 8'h41);
        press(1'b1, 1);
        chk("up_b", sel_letter, 8'h42);
        exp_q.push_back(8'h42);
        BtnC_pulse = 1'b1;
        BtnU_pulse = 1'b1;
        tick();
        BtnC_pulse = 1'b0;
        BtnU_pulse = 1'b0;
        chk("cwin_out", letter_out, 8'h42);
        chk("cwin_sel", sel_letter, 8'h42);
        chk("cwin_send", q_Send, 1'b1);
        repeat (5) begin
            BtnU_pulse = 1'b1;
            tick();
            BtnU_pulse = 1'b0;
            tick();
        end
        chk("hold_valid", letter_valid, 1'b1);
        chk("hold_out", letter_out, 8'h42);
        chk("hold_sel", sel_letter, 8'h42);
        letter_ready = 1'b1;
        tick();
        chk("hold_xfer_valid", letter_valid, 1'b0);
        chk("hold_xfer_pos", pos, 3'd2);
        chk("hold_xfer_sel", sel_letter, 8'h41);
        tick();
        chk("idle_ready_pos", pos, 3'd2);
        chk("idle_ready_valid", letter_valid, 1'b0);
        letter_ready = 1'b0;
        BtnC_pulse = 1'b1;
        tick();
        BtnC_pulse = 1'b0;
        chk("abort_send", q_Send, 1'b1);
        enable = 1'b0;
        tick();
        chk("abort_valid", letter_valid, 1'b0);
        chk("abort_dis", q_Dis, 1'b1);
        chk("abort_pos", pos, 3'd0);
        chk("abort_sel", sel_letter, 8'h41);
        BtnU_pulse = 1'b1;
        BtnC_pulse = 1'b1;
        tick();
        BtnU_pulse = 1'b0;
        BtnC_pulse = 1'b0;
        chk("dis_ignore_state", q_Dis, 1'b1);
        chk("dis_ignore_sel", sel_letter, 8'h41);
        chk("dis_ignore_valid", letter_valid, 1'b0);
        enable = 1'b1;
        tick();
        chk("reenable_sel", q_Sel, 1'b1);
        letter_ready = 1'b1;
        send_letter(8'h52, 1'b1, 17, 3'd1);
        send_letter(8'h45, 1'b1, 4, 3'd2);
        send_letter(8'h4E, 1'b1, 13, 3'd3);
        send_letter(8'h45, 1'b1, 4, 3'd4);
        send_letter(8'h57, 1'b0, 4, 3'd0);
        chk("word_sent", word_sent, 1'b1);
        chk("end_state", q_End, 1'b1);
        tick();
        chk("ws_drop", word_sent, 1'b0);
        chk("post_word_sel", q_Sel, 1'b1);
        chk("post_word_pos", pos, 3'd0);
        send_letter(8'h41, 1'b1, 0, 3'd1);
        send_letter(8'h41, 1'b1, 0, 3'd2);
        send_letter(8'h41, 1'b1, 0, 3'd3);
        letter_ready = 1'b0;
        press(1'b1, 2);
        BtnC_pulse = 1'b1;
        tick();
        BtnC_pulse = 1'b0;
        chk("pre_rst_send", q_Send, 1'b1);
        chk("pre_rst_pos", pos, 3'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", letter_valid, 1'b0);
        chk("arst_out", letter_out, 8'h00);
        chk("arst_sel", sel_letter, 8'h41);
        chk("arst_pos", pos, 3'd0);
        chk("arst_ws", word_sent, 1'b0);
        chk("arst_dis", q_Dis, 1'b1);
        chk("arst_send", q_Send, 1'b0);
        chk("xfer_count", n_xfer, 10);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
